ahb_gpio_param: RTL and testbench

//  Parametrised AHB-Lite GPIO slave: width-configurable port, per-bit direction, input synchroniser,

---
 rtl/ahb_gpio_param.sv | 139 +++++++++++++
 tb/tb_ahb_gpio_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_param.sv
// AHB-Lite GPIO slave: width-configurable port, per-bit direction, synchronised inputs,
// edge interrupts with W1C status. Define GPIO_PARITY_EN to enable input parity checking.
module ahb_gpio_param #(
    parameter int unsigned GPIO_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    input  logic [GPIO_WIDTH:0]   GPIOIN,
    input  logic                  PARITYSEL,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIODIR,
    output logic                  IRQ,
    output logic                  PARITYERR
);
    localparam int unsigned W = GPIO_WIDTH;

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_DIR      = 3'd1,
        REG_IRQ_EN   = 3'd2,
        REG_IRQ_STAT = 3'd3,
        REG_IRQ_POL  = 3'd4,
        REG_PERR     = 3'd5
    } reg_addr_e;

    logic         valid_q, write_q, addr_ok, wr;
    logic [2:0]   addr_q;
    logic [W:0]   sync_q [SYNC_STAGES];
    logic [W-1:0] sync_in, prev_q, wdata, edge_set, rd_field;
    logic [W-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [W-1:0] stat_q, stat_d, pol_q, pol_d;
    logic         irq_q, irq_d, perr_q, perr_d, perr_stat_q, perr_stat_d;
    logic         unused_bus;

    assign addr_ok    = HSEL & HREADY & HTRANS[1];
    assign wr         = valid_q & write_q;
    assign wdata      = HWDATA[W-1:0];
    assign sync_in    = sync_q[SYNC_STAGES-1][W-1:0];
    assign unused_bus = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:W]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q      <= '0;
            out_q       <= '0;
            dir_q       <= '0;
            en_q        <= '0;
            stat_q      <= '0;
            pol_q       <= '0;
            irq_q       <= 1'b0;
            perr_q      <= 1'b0;
            perr_stat_q <= 1'b0;
        end else begin
            valid_q <= addr_ok;
            if (addr_ok) begin
                addr_q  <= HADDR[4:2];
                write_q <= HWRITE;
            end
            sync_q[0] <= GPIOIN;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q      <= sync_in;
            out_q       <= out_d;
            dir_q       <= dir_d;
            en_q        <= en_d;
            stat_q      <= stat_d;
            pol_q       <= pol_d;
            irq_q       <= irq_d;
            perr_q      <= perr_d;
            perr_stat_q <= perr_stat_d;
        end
    end

    // Edge source is the synchronised value only, so flipping DIR never fabricates an edge.
    assign edge_set = ~dir_q & ((pol_q & sync_in & ~prev_q) | (~pol_q & ~sync_in & prev_q));

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        pol_d  = pol_q;
        stat_d = stat_q;
        if (wr && addr_q == REG_DATA)     out_d  = wdata;
        if (wr && addr_q == REG_DIR)      dir_d  = wdata;
        if (wr && addr_q == REG_IRQ_EN)   en_d   = wdata;
        if (wr && addr_q == REG_IRQ_POL)  pol_d  = wdata;
        if (wr && addr_q == REG_IRQ_STAT) stat_d = stat_q & ~wdata;
        stat_d = stat_d | edge_set;
        irq_d  = |(stat_q & en_q);
    end

`ifdef GPIO_PARITY_EN
    logic perr_now;
    always_comb begin
        perr_now    = (^sync_q[SYNC_STAGES-1]) != PARITYSEL;
        perr_d      = perr_now;
        perr_stat_d = perr_stat_q;
        if (wr && addr_q == REG_PERR && wdata[0]) perr_stat_d = 1'b0;
        if (perr_now) perr_stat_d = 1'b1;
    end
`else
    logic unused_parity;
    assign unused_parity = ^{sync_q[SYNC_STAGES-1][W], PARITYSEL};
    assign perr_d        = 1'b0;
    assign perr_stat_d   = 1'b0;
`endif

    always_comb begin
        rd_field = '0;
        case (addr_q)
            REG_DATA:     rd_field = (dir_q & out_q) | (~dir_q & sync_in);
            REG_DIR:      rd_field = dir_q;
            REG_IRQ_EN:   rd_field = en_q;
            REG_IRQ_STAT: rd_field = stat_q;
            REG_IRQ_POL:  rd_field = pol_q;
            REG_PERR:     rd_field[0] = perr_stat_q;
            default:      rd_field = '0;
        endcase
        HRDATA = '0;
        if (valid_q && !write_q) HRDATA[W-1:0] = rd_field;
    end

    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = out_q;
    assign GPIODIR   = dir_q;
    assign IRQ       = irq_q;
    assign PARITYERR = perr_q;
endmodule

// File: tb/tb_ahb_gpio_param.sv
// Self-checking bench for ahb_gpio_param (GPIO_WIDTH=16, SYNC_STAGES=2) with a register-level model.
module tb_ahb_gpio_param;
    localparam int W = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = '0;
    logic          HWRITE = 1'b0;
    logic [31:0]   HWDATA = '0;
    logic          HREADY = 1'b1;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic [W:0]    GPIOIN = '0;
    logic          PARITYSEL = 1'b0;
    logic [W-1:0]  GPIOOUT, GPIODIR;
    logic          IRQ, PARITYERR;

    ahb_gpio_param #(.GPIO_WIDTH(W), .SYNC_STAGES(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .GPIOIN(GPIOIN), .PARITYSEL(PARITYSEL), .GPIOOUT(GPIOOUT),
        .GPIODIR(GPIODIR), .IRQ(IRQ), .PARITYERR(PARITYERR)
    );

    always #5 HCLK = ~HCLK;

    // Reference state: register contents and the settled pad value.
    logic [15:0] m_out, m_dir, m_en, m_stat, m_pol, m_pad;
    logic        m_perr;
    int          n_checks = 0, n_pass = 0, n_fail = 0;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        bus_idle();
        HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        bus_idle();
        data = HRDATA;
        tick();
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_pol = '0; m_perr = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        case (addr)
            32'h00: m_out = data[15:0];
            32'h04: m_dir = data[15:0];
            32'h08: m_en  = data[15:0];
            32'h0C: m_stat = m_stat & ~data[15:0];
            32'h10: m_pol = data[15:0];
`ifdef GPIO_PARITY_EN
            32'h14: m_perr = m_perr & ~data[0];
`endif
            default: ;
        endcase
        ahb_write(addr, data);
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        case (addr)
            32'h00:  return {16'h0, (m_dir & m_out) | (~m_dir & m_pad)};
            32'h04:  return {16'h0, m_dir};
            32'h08:  return {16'h0, m_en};
            32'h0C:  return {16'h0, m_stat};
            32'h10:  return {16'h0, m_pol};
            32'h14:  return {31'h0, m_perr};
            default: return 32'h0;
        endcase
    endfunction

    // Drive pads with good even parity in the MSB and record any qualifying edges.
    task automatic set_pads(input logic [15:0] v, input int settle);
        logic [15:0] rise, fall;
        rise   = ~m_pad & v;
        fall   = m_pad & ~v;
        m_stat = m_stat | (~m_dir & ((m_pol & rise) | (~m_pol & fall)));
        m_pad  = v;
        GPIOIN = {^v, v};
        repeat (settle) tick();
    endtask

    task automatic check_all_regs(input string tag);
        for (int a = 0; a < 6; a++) begin
            ahb_read(32'(a * 4), rd);
            check($sformatf("%s_reg%0h", tag, a * 4), rd, exp_read(32'(a * 4)));
        end
        check({tag, "_irq"}, {31'h0, IRQ}, {31'h0, |(m_stat & m_en)});
        check({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
    endtask

    initial begin
        model_reset();
        m_pad = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        tick();

        // Reset arriving during a write data phase
        model_write(32'h00, 32'h1234);
        check("data_before_reset", {16'h0, GPIOOUT}, 32'h1234);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        bus_idle();
        HWDATA = 32'hFFFF;
        #2 HRESETn = 1'b0;
        #1;
        model_reset();
        check("rst_gpioout", {16'h0, GPIOOUT}, 32'h0);
        check("rst_gpiodir", {16'h0, GPIODIR}, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("rst_parityerr", {31'h0, PARITYERR}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        tick();
        check("post_rst_dir", {16'h0, GPIODIR}, 32'h0);
        check_all_regs("post_rst");

        // Mixed direction DATA read
        model_write(32'h04, 32'h00FF);
        model_write(32'h00, 32'hA5A5);
        set_pads(16'h3C00, 4);
        check("gpioout_a5a5", {16'h0, GPIOOUT}, 32'hA5A5);
        ahb_read(32'h00, rd);
        check("data_mixed", rd, 32'h3CA5);

        // Rising-edge interrupt latency on bit 8
        model_write(32'h10, 32'h0100);
        model_write(32'h08, 32'h0100);
        set_pads(16'h3D00, 0);
        tick(); tick();
        check("irq_sync2", {31'h0, IRQ}, 32'h0);
        tick();
        check("irq_at_status", {31'h0, IRQ}, 32'h0);
        tick();
        check("irq_asserted", {31'h0, IRQ}, 32'h1);
        ahb_read(32'h0C, rd);
        check("status_bit8", rd, 32'h0100);
        model_write(32'h0C, 32'h0100);
        check("irq_hold_after_w1c", {31'h0, IRQ}, 32'h1);
        tick();
        check("irq_drop", {31'h0, IRQ}, 32'h0);
        ahb_read(32'h0C, rd);
        check("status_cleared", rd, 32'h0);

        // Edge coinciding with W1C of the same bit
        set_pads(16'h3C00, 4);
        set_pads(16'h3D00, 0);
        tick();
        model_write(32'h0C, 32'h0100);
        m_stat = m_stat | 16'h0100;
        ahb_read(32'h0C, rd);
        check("set_beats_clear", rd, 32'h0100);
        model_write(32'h0C, 32'h0100);
        tick();
        check_all_regs("after_clear");

        // Back-to-back write then read of DIR
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        HWDATA = 32'h0F0F; HWRITE = 1'b0;
        m_dir = 16'h0F0F;
        tick();
        bus_idle();
        check("b2b_read", HRDATA, 32'h0F0F);
        tick();

        // Randomised register and pad traffic
        for (int it = 0; it < 8; it++) begin
            model_write(32'h04, 32'($urandom_range(0, 16'hFFFF)));
            model_write(32'h10, 32'($urandom_range(0, 16'hFFFF)));
            model_write(32'h08, 32'($urandom_range(0, 16'hFFFF)));
            model_write(32'h00, $urandom);
            set_pads(16'($urandom_range(0, 16'hFFFF)), 4);
            check_all_regs($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_perr", it), {31'h0, PARITYERR}, 32'h0);
            model_write(32'h0C, 32'($urandom_range(0, 16'hFFFF)));
            ahb_read(32'h0C, rd);
            check($sformatf("rnd%0d_w1c", it), rd, exp_read(32'h0C));
        end

        // Parity
        PARITYSEL = 1'b0;
        set_pads(16'h0001, 4);
        check("parity_ok", {31'h0, PARITYERR}, 32'h0);
        GPIOIN = 17'h0_0001;
        tick(); tick();
        check("parity_sync2", {31'h0, PARITYERR}, 32'h0);
        tick();
`ifdef GPIO_PARITY_EN
        m_perr = 1'b1;
        check("parity_err", {31'h0, PARITYERR}, 32'h1);
`else
        check("parity_err_disabled", {31'h0, PARITYERR}, 32'h0);
`endif
        ahb_read(32'h14, rd);
        check("perr_status", rd, exp_read(32'h14));
        set_pads(16'h0001, 4);
        check("parity_recovered", {31'h0, PARITYERR}, 32'h0);
        ahb_read(32'h14, rd);
        check("perr_sticky", rd, exp_read(32'h14));
        model_write(32'h14, 32'h1);
        ahb_read(32'h14, rd);
        check("perr_w1c", rd, 32'h0);

        // Unmapped offsets and non-transfers have no effect
        ahb_read(32'h18, rd);
        check("read_0x18", rd, 32'h0);
        ahb_write(32'h1C, 32'hFFFF_FFFF);
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h00;
        tick();
        bus_idle();
        HWDATA = {16'h0, ~m_out};
        tick();
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h04;
        tick();
        bus_idle();
        check("hsel0_hrdata", HRDATA, 32'h0);
        tick();
        check("idle_no_write", {16'h0, GPIOOUT}, {16'h0, m_out});
        check_all_regs("unmapped");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
